// File: rtl/clk_gen_multi.sv
// Multi-channel programmable clock divider with phase preload and lock tracking.
// Every accepted in-range write restarts all channels together.
module clk_gen_multi #(
   parameter int NUM_CLOCKS  = 4,
   parameter int DIV_WIDTH   = 16,
   parameter int DEFAULT_DIV = 8,
   parameter int LOCK_CYCLES = 16
) (
   input  logic                  refclk,
   input  logic                  rst,
   input  logic                  cfg_valid,
   output logic                  cfg_ready,
   input  logic [3:0]            cfg_chan,
   input  logic [DIV_WIDTH-1:0]  cfg_div,
   input  logic [DIV_WIDTH-1:0]  cfg_phase,
   output logic [NUM_CLOCKS-1:0] outclk,
   output logic [NUM_CLOCKS-1:0] tick,
   output logic                  locked
);

   localparam int SW = $clog2(LOCK_CYCLES) + 1;

   typedef enum logic [1:0] {
      S_RESET,
      S_APPLY,
      S_SETTLE,
      S_LOCKED
   } state_t;

   state_t state_q, state_d;

   logic [SW-1:0]        settle_q, settle_d;
   logic [DIV_WIDTH-1:0] div_q   [NUM_CLOCKS];
   logic [DIV_WIDTH-1:0] phase_q [NUM_CLOCKS];
   logic [DIV_WIDTH-1:0] cnt_q   [NUM_CLOCKS];
   logic [DIV_WIDTH-1:0] cnt_d   [NUM_CLOCKS];
   logic [NUM_CLOCKS-1:0] outclk_q, outclk_d;
   logic [NUM_CLOCKS-1:0] tick_q, tick_d;

   logic accept;
   logic chan_ok;
   logic relock;
   logic run_next;

   assign cfg_ready = (state_q == S_SETTLE) || (state_q == S_LOCKED);
   assign accept    = cfg_valid && cfg_ready;
   assign chan_ok   = int'(cfg_chan) < NUM_CLOCKS;
   assign relock    = accept && chan_ok;
   assign locked    = (state_q == S_LOCKED);
   assign outclk    = outclk_q;
   assign tick      = tick_q;

   always_comb begin
      state_d  = state_q;
      settle_d = settle_q;
      unique case (state_q)
         S_RESET: state_d = S_APPLY;
         S_APPLY: begin
            state_d  = S_SETTLE;
            settle_d = '0;
         end
         S_SETTLE: begin
            if (settle_q == SW'(LOCK_CYCLES - 1))
               state_d = S_LOCKED;
            else
               settle_d = settle_q + SW'(1);
         end
         S_LOCKED: state_d = S_LOCKED;
         default:  state_d = S_RESET;
      endcase
      if (relock)
         state_d = S_APPLY;
   end

   // Outputs decode the counter's next value, so they line up with it.
   assign run_next = (state_d == S_SETTLE) || (state_d == S_LOCKED);

   always_comb begin
      for (int i = 0; i < NUM_CLOCKS; i++) begin
         cnt_d[i]    = '0;
         outclk_d[i] = 1'b0;
         tick_d[i]   = 1'b0;
         if (div_q[i] >= DIV_WIDTH'(2)) begin
            if (state_q == S_APPLY) begin
               if (phase_q[i] < div_q[i])
                  cnt_d[i] = phase_q[i];
            end else if (cfg_ready) begin
               if (cnt_q[i] != div_q[i] - DIV_WIDTH'(1))
                  cnt_d[i] = cnt_q[i] + DIV_WIDTH'(1);
            end
            if (run_next) begin
               outclk_d[i] = cnt_d[i] < (div_q[i] >> 1);
               tick_d[i]   = cnt_d[i] == '0;
            end
         end
      end
   end

   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         state_q  <= S_RESET;
         settle_q <= '0;
         outclk_q <= '0;
         tick_q   <= '0;
         for (int i = 0; i < NUM_CLOCKS; i++) begin
            div_q[i]   <= DIV_WIDTH'(DEFAULT_DIV);
            phase_q[i] <= '0;
            cnt_q[i]   <= '0;
         end
      end else begin
         state_q  <= state_d;
         settle_q <= settle_d;
         outclk_q <= outclk_d;
         tick_q   <= tick_d;
         for (int i = 0; i < NUM_CLOCKS; i++) begin
            cnt_q[i] <= cnt_d[i];
            if (relock && cfg_chan == 4'(i)) begin
               div_q[i]   <= cfg_div;
               phase_q[i] <= cfg_phase;
            end
         end
      end
   end

endmodule
